// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- parametrised program-counter generator for the fetch stage.
//
// Produces the instruction fetch address and handles sequential stepping,
// fetch stall, trap redirect (saving the faulting PC in epc), call/return
// through a circular return-address stack, and misaligned jump targets.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   stall         in   hold PC, RAS and epc this cycle (trap still wins)
//   j_signal      in   take jump/branch to 'jump'
//   jump          in   jump/branch target [XLEN]
//   link          in   qualifies j_signal as a call (push return address)
//   ret_req       in   return: next PC popped from the RAS
//   trap_req      in   external trap request
//   out           out  current PC / fetch address [XLEN]
//   pc_next_seq   out  combinational out + STEP [XLEN]
//   epc           out  PC saved at the last trap [XLEN]
//   ras_count     out  number of valid RAS entries
//   misalign_err  out  one-cycle pulse after a misaligned jump target
//   ras_underflow out  one-cycle pulse after a return with an empty RAS
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned     STEP         = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         j_signal,
    input  logic [XLEN-1:0]              jump,
    input  logic                         link,
    input  logic                         ret_req,
    input  logic                         trap_req,
    output logic [XLEN-1:0]              out,
    output logic [XLEN-1:0]              pc_next_seq,
    output logic [XLEN-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         misalign_err,
    output logic                         ras_underflow
);

    localparam int unsigned     ALIGN_W = $clog2(STEP);
    localparam int unsigned     PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W   = PTR_W + 1;
    localparam logic [XLEN-1:0] STEP_V  = XLEN'(STEP);
    localparam logic [CNT_W-1:0] FULL_V = CNT_W'(RAS_DEPTH);

    // One action per edge, chosen in strict priority order.
    typedef enum logic [2:0] {
        ACT_SEQ,
        ACT_TRAP,
        ACT_HOLD,
        ACT_POP,
        ACT_UNDERFLOW,
        ACT_MISALIGN,
        ACT_JUMP
    } act_t;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [CNT_W-1:0] r_count;
    logic             r_misalign;
    logic             r_underflow;

    logic [XLEN-1:0]  w_pc_seq;
    logic [PTR_W-1:0] w_wp_dec;
    logic             w_misaligned;
    act_t             w_act;

    assign w_pc_seq     = r_pc + STEP_V;
    assign w_wp_dec     = r_wp - PTR_W'(1);
    assign w_misaligned = |jump[ALIGN_W-1:0];

    always_comb begin
        w_act = ACT_SEQ;
        if (trap_req) begin
            w_act = ACT_TRAP;
        end else if (stall) begin
            w_act = ACT_HOLD;
        end else if (ret_req) begin
            // A simultaneous jump is dropped: no push and pop in one cycle.
            w_act = (r_count != '0) ? ACT_POP : ACT_UNDERFLOW;
        end else if (j_signal) begin
            w_act = w_misaligned ? ACT_MISALIGN : ACT_JUMP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_VECTOR;
            r_epc       <= '0;
            r_wp        <= '0;
            r_count     <= '0;
            r_misalign  <= 1'b0;
            r_underflow <= 1'b0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            // Pulses default low every edge, including stalled ones.
            r_misalign  <= 1'b0;
            r_underflow <= 1'b0;
            case (w_act)
                ACT_TRAP: begin
                    r_pc  <= TRAP_VECTOR;
                    r_epc <= r_pc;
                end
                ACT_HOLD: begin
                end
                ACT_POP: begin
                    r_pc    <= r_ras[w_wp_dec];
                    r_wp    <= w_wp_dec;
                    r_count <= r_count - CNT_W'(1);
                end
                ACT_UNDERFLOW: begin
                    r_pc        <= w_pc_seq;
                    r_underflow <= 1'b1;
                end
                ACT_MISALIGN: begin
                    r_pc       <= TRAP_VECTOR;
                    r_epc      <= r_pc;
                    r_misalign <= 1'b1;
                end
                ACT_JUMP: begin
                    r_pc <= jump;
                    if (link) begin
                        // Circular push: a full stack overwrites its oldest entry.
                        r_ras[r_wp] <= w_pc_seq;
                        r_wp        <= r_wp + PTR_W'(1);
                        if (r_count != FULL_V) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_pc <= w_pc_seq;
                end
            endcase
        end
    end

    assign out           = r_pc;
    assign pc_next_seq   = w_pc_seq;
    assign epc           = r_epc;
    assign ras_count     = r_count;
    assign misalign_err  = r_misalign;
    assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall, j_signal, link, ret_req, trap_req;
    logic [31:0] jump;
    logic [31:0] out, pc_next_seq, epc;
    logic [2:0]  ras_count;
    logic        misalign_err, ras_underflow;

    logic        w8_stall, w8_j, w8_link, w8_ret, w8_trap;
    logic [7:0]  w8_jump;
    logic [7:0]  w8_out, w8_next, w8_epc;
    logic [2:0]  w8_count;
    logic        w8_mis, w8_unf;

    int total;
    int bad;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .j_signal(j_signal),
        .jump(jump), .link(link), .ret_req(ret_req), .trap_req(trap_req),
        .out(out), .pc_next_seq(pc_next_seq), .epc(epc),
        .ras_count(ras_count), .misalign_err(misalign_err),
        .ras_underflow(ras_underflow)
    );

    pc_gen #(
        .XLEN(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80),
        .STEP(4), .RAS_DEPTH(4)
    ) dut8 (
        .clk(clk), .reset(reset), .stall(w8_stall), .j_signal(w8_j),
        .jump(w8_jump), .link(w8_link), .ret_req(w8_ret), .trap_req(w8_trap),
        .out(w8_out), .pc_next_seq(w8_next), .epc(w8_epc),
        .ras_count(w8_count), .misalign_err(w8_mis),
        .ras_underflow(w8_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        stall = 0; j_signal = 0; link = 0; ret_req = 0; trap_req = 0; jump = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle();
        w8_stall = 0; w8_j = 0; w8_link = 0; w8_ret = 0; w8_trap = 0; w8_jump = '0;
        repeat (3) tick();
        total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
        total++; if ({misalign_err, ras_underflow} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {misalign_err, ras_underflow}); end
        reset = 1'b1;
    endtask

    task automatic test_free_run;
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL run_start got=%h exp=%h", out, 32'h0); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out !== exp_pc[i]) begin bad++; $display("FAIL run_out[%0d] got=%h exp=%h", i, out, exp_pc[i]); end
            total++; if (pc_next_seq !== exp_pc[i] + 32'h4) begin bad++; $display("FAIL run_next[%0d] got=%h exp=%h", i, pc_next_seq, exp_pc[i] + 32'h4); end
        end
    endtask

    // out = 0x10 on entry
    task automatic test_call_ret;
        j_signal = 1; link = 1; jump = 32'h200;
        tick();
        idle();
        total++; if (out !== 32'h200) begin bad++; $display("FAIL call_out got=%h exp=%h", out, 32'h200); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL call_count got=%0d exp=1", ras_count); end
        tick(); tick();
        total++; if (out !== 32'h208) begin bad++; $display("FAIL call_adv got=%h exp=%h", out, 32'h208); end
        ret_req = 1;
        tick();
        idle();
        total++; if (out !== 32'h14) begin bad++; $display("FAIL ret_out got=%h exp=%h", out, 32'h14); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL ret_count got=%0d exp=0", ras_count); end
    endtask

    // out = 0x14 on entry
    task automatic test_overflow;
        logic [31:0] ret_exp [4];
        logic [2:0]  cnt_exp [5];
        ret_exp[0] = 32'h4004; ret_exp[1] = 32'h3004; ret_exp[2] = 32'h2004; ret_exp[3] = 32'h1004;
        cnt_exp[0] = 3'd1; cnt_exp[1] = 3'd2; cnt_exp[2] = 3'd3; cnt_exp[3] = 3'd4; cnt_exp[4] = 3'd4;
        for (int i = 0; i < 5; i++) begin
            j_signal = 1; link = 1; jump = 32'h1000 * (i + 1);
            tick();
            total++; if (ras_count !== cnt_exp[i]) begin bad++; $display("FAIL push_count[%0d] got=%0d exp=%0d", i, ras_count, cnt_exp[i]); end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            ret_req = 1;
            tick();
            total++; if (out !== ret_exp[i]) begin bad++; $display("FAIL pop_out[%0d] got=%h exp=%h", i, out, ret_exp[i]); end
            total++; if (ras_count !== 3'(3 - i)) begin bad++; $display("FAIL pop_count[%0d] got=%0d exp=%0d", i, ras_count, 3 - i); end
        end
        tick();
        idle();
        total++; if (out !== 32'h1008) begin bad++; $display("FAIL unf_out got=%h exp=%h", out, 32'h1008); end
        total++; if (ras_underflow !== 1'b1) begin bad++; $display("FAIL unf_pulse got=%b exp=1", ras_underflow); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL unf_count got=%0d exp=0", ras_count); end
        tick();
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", ras_underflow); end
        total++; if (out !== 32'h100C) begin bad++; $display("FAIL unf_next got=%h exp=%h", out, 32'h100C); end
    endtask

    // out = 0x100C on entry
    task automatic test_trap_over_stall;
        j_signal = 1; link = 1; jump = 32'h40;
        tick();
        total++; if (out !== 32'h40) begin bad++; $display("FAIL pre_trap_out got=%h exp=%h", out, 32'h40); end
        stall = 1; trap_req = 1; j_signal = 1; link = 0; jump = 32'h300;
        tick();
        idle();
        total++; if (out !== 32'h100) begin bad++; $display("FAIL trap_out got=%h exp=%h", out, 32'h100); end
        total++; if (epc !== 32'h40) begin bad++; $display("FAIL trap_epc got=%h exp=%h", epc, 32'h40); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL trap_count got=%0d exp=1", ras_count); end
    endtask

    // out = 0x100 on entry, RAS holds 0x1010
    task automatic test_misalign;
        tick();
        j_signal = 1; link = 1; jump = 32'h202;
        tick();
        idle();
        total++; if (out !== 32'h100) begin bad++; $display("FAIL mis_out got=%h exp=%h", out, 32'h100); end
        total++; if (epc !== 32'h104) begin bad++; $display("FAIL mis_epc got=%h exp=%h", epc, 32'h104); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
        total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL mis_count got=%0d exp=1", ras_count); end
        tick();
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
        total++; if (out !== 32'h104) begin bad++; $display("FAIL mis_next got=%h exp=%h", out, 32'h104); end
    endtask

    task automatic test_stall;
        j_signal = 1; jump = 32'h80;
        tick();
        stall = 1; j_signal = 1; link = 1; ret_req = 1; jump = 32'h500;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out !== 32'h80) begin bad++; $display("FAIL stall_out[%0d] got=%h exp=%h", i, out, 32'h80); end
            total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=1", i, ras_count); end
        end
        idle();
        tick();
        total++; if (out !== 32'h84) begin bad++; $display("FAIL stall_release got=%h exp=%h", out, 32'h84); end
    endtask

    // RAS holds 0x1010; a ret with a simultaneous call must pop only
    task automatic test_ret_vs_jump;
        ret_req = 1; j_signal = 1; link = 1; jump = 32'h900;
        tick();
        idle();
        total++; if (out !== 32'h1010) begin bad++; $display("FAIL retj_out got=%h exp=%h", out, 32'h1010); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL retj_count got=%0d exp=0", ras_count); end
        link = 1;
        tick();
        idle();
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL link_only got=%0d exp=0", ras_count); end
        total++; if (out !== 32'h1014) begin bad++; $display("FAIL link_only_out got=%h exp=%h", out, 32'h1014); end
    endtask

    task automatic test_async_reset;
        ret_req = 1;
        tick();
        idle();
        total++; if (ras_underflow !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b exp=1", ras_underflow); end
        #2 reset = 1'b0;
        #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL ar_out got=%h exp=%h", out, 32'h0); end
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL ar_pulse got=%b exp=0", ras_underflow); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL ar_epc got=%h exp=%h", epc, 32'h0); end
        tick();
        reset = 1'b1;
        tick();
        total++; if (out !== 32'h4) begin bad++; $display("FAIL ar_release got=%h exp=%h", out, 32'h4); end
    endtask

    task automatic test_wrap;
        w8_j = 1; w8_jump = 8'hFC;
        tick();
        w8_j = 0; w8_jump = '0;
        total++; if (w8_out !== 8'hFC) begin bad++; $display("FAIL wrap_at got=%h exp=%h", w8_out, 8'hFC); end
        total++; if (w8_next !== 8'h00) begin bad++; $display("FAIL wrap_next got=%h exp=%h", w8_next, 8'h00); end
        tick();
        total++; if (w8_out !== 8'h00) begin bad++; $display("FAIL wrap_out got=%h exp=%h", w8_out, 8'h00); end
        w8_j = 1; w8_jump = 8'h41;
        tick();
        w8_j = 0; w8_jump = '0;
        total++; if (w8_out !== 8'h80 || w8_mis !== 1'b1 || w8_epc !== 8'h00) begin
            bad++; $display("FAIL wrap_mis got=%h/%b/%h exp=80/1/00", w8_out, w8_mis, w8_epc);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_free_run();
        test_call_ret();
        test_overflow();
        test_trap_over_stall();
        test_misalign();
        test_stall();
        test_ret_vs_jump();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC that has only an increment/jump/reset path.
- Adds the following:
  - configurable width, reset vector and step
  - fetch stall
  - trap redirect with saved exception PC
  - a circular return-address stack (RAS) for call/return
  - misaligned-target detection
- Drives the instruction-memory address and feeds the decode/branch unit.

Parameters:
- XLEN, 32: PC and target width in bits (≥ 8).
- RESET_VECTOR, 0: PC value after reset.
- TRAP_VECTOR, 32'h0000_0100: redirect address on trap or misaligned target.
- STEP, 4: increment per non-redirect cycle; must be a power of two ≥ 2.
- RAS_DEPTH, 4: return-address stack entries; must be a power of two, ≥ 2.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- stall, input, 1: hold the PC this cycle.
- j_signal, input, 1: take a jump or branch to jump.
- jump, input, XLEN: jump or branch target.
- link, input, 1: qualifies j_signal as a call, which pushes the return address.
- ret_req, input, 1: return; the next PC is popped from the RAS.
- trap_req, input, 1: external trap request.
- out, output, XLEN: current PC (the fetch address).
- pc_next_seq, output, XLEN: combinational out + STEP.
- epc, output, XLEN: PC saved at the last trap.
- ras_count, output, clog2(RAS_DEPTH)+1: number of valid RAS entries.
- misalign_err, output, 1: one-cycle pulse when a jump target was misaligned.
- ras_underflow, output, 1: one-cycle pulse when ret_req was seen with the RAS empty.

Behaviour:
- Reset (asynchronous, on reset low):
  - out = RESET_VECTOR; epc = 0; ras_count = 0; all RAS entries = 0; misalign_err = 0; ras_underflow = 0.
  - Release is synchronous to clk. The first rising edge with reset high applies the normal update rules.
- Registered update, one per rising edge, in strict priority order:
  1. trap_req: out <= TRAP_VECTOR; epc <= out. The RAS is unchanged. Trap overrides stall.
  2. stall: out, RAS and epc hold. j_signal, ret_req and link are ignored. Upstream must keep them asserted until stall drops.
  3. ret_req:
     - If ras_count > 0: out <= top entry; ras_count decrements.
     - If ras_count = 0: out <= out + STEP; ras_underflow pulses for one cycle.
  4. j_signal with a misaligned target (jump[clog2(STEP)-1:0] ≠ 0):
     - out <= TRAP_VECTOR; epc <= out; misalign_err pulses. No RAS push occurs.
  5. j_signal with an aligned target:
     - out <= jump.
     - If link = 1, push out + STEP.
     - On a full-stack push, the oldest entry is overwritten (circular buffer) and ras_count saturates at RAS_DEPTH.
  6. Otherwise: out <= out + STEP.
- Exclusivity rules:
  - ret_req and j_signal together: ret wins and the jump is dropped. There is no simultaneous push and pop.
  - link without j_signal is ignored.
- Arithmetic:
  - All additions are modulo 2^XLEN, so out + STEP wraps to 0 at the top of the address space with no flag.
  - pc_next_seq is combinational, zero latency from out.
- RAS structure:
  - Write pointer wp of width clog2(RAS_DEPTH).
  - Push writes entry[wp] and then increments wp.
  - Pop reads entry[wp-1] and then decrements wp. Both wrap modulo RAS_DEPTH.
- Pulse outputs: misalign_err and ras_underflow are registered and high for exactly the cycle after the causing edge. Both clear under stall.
- Latency: a redirect presented before edge N is visible on out immediately after edge N (one-cycle redirect latency).
- Reset mid-operation: an asynchronous assert clears all state immediately, including pending pulses. It does not wait for a clock edge.

Test Plan:
1. Reset then free-run: reset low 3 cycles, then high with no requests → out = 0, 4, 8, 12 on successive edges; pc_next_seq = out + 4.
2. Call/return:
   - Step A: at out = 0x10, assert j_signal = 1, link = 1, jump = 0x200 → out = 0x200, ras_count = 1.
   - Step B: advance two cycles, then assert ret_req → out = 0x14, ras_count = 0.
3. Overflow and underflow:
   - Step A: perform 5 calls with RAS_DEPTH = 4 → ras_count stays at 4.
   - Step B: perform 4 returns → they yield the last 4 return addresses in LIFO order.
   - Step C: a 5th return → ras_underflow pulses and out advances by 4.
4. Trap over stall: stall = 1, trap_req = 1, j_signal = 1 at out = 0x40 → out = 0x100, epc = 0x40, ras_count unchanged.
5. Misaligned target: jump = 0x202 with j_signal → out = 0x100, epc = previous out, misalign_err high for exactly one cycle, no push.
6. Stall and wrap:
   - Step A: stall for 3 cycles at out = 0x80 → out holds at 0x80 and the jump presented during the stall is ignored.
   - Step B: with XLEN = 8, out = 0xFC and no requests → next out = 0x00.
